fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
- Controls the two EX-stage operand forwarding muxes of the 5-stage RV32 pipeline. These are the 3:1 muxes on ALU operand A and operand B.
- Tracks destination registers of in-flight instructions in its own ID/EX, EX/MEM and MEM/WB shadow registers.
- Generates per-operand mux selects, the load-use stall and bubble insertion.
- Keeps a saturating stall counter for performance monitoring.
- Sits beside the pipeline registers; it consumes decode fields from ID and the flush from branch resolution.

Parameters:
- REG_AW, 5, register-address width (x0..x31).
- CNT_W, 16, stall-counter width.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_rs1  input  REG_AW  source register 1 of ID instruction.
- id_rs2  input  REG_AW  source register 2 of ID instruction.
- id_use_rs1  input  1  ID instruction reads rs1.
- id_use_rs2  input  1  ID instruction reads rs2.
- id_rd  input  REG_AW  destination of ID instruction.
- id_reg_write  input  1  ID instruction writes rd.
- id_mem_read  input  1  ID instruction is a load.
- flush  input  1  branch/jump taken in EX; kill the ID instruction.
- fwd_a_sel  output  2  operand A select: 00 regfile, 01 EX/MEM result, 10 MEM/WB result.
- fwd_b_sel  output  2  operand B select, same encoding.
- stall  output  1  hold PC and IF/ID; insert bubble into ID/EX.
- stall_count  output  CNT_W  saturating count of stall cycles.

Behaviour:
- Internal stage records: EX, MEM and WB each hold {valid, rd, reg_write, mem_read}. EX also holds {rs1, rs2, use_rs1, use_rs2}.
- Reset (async, immediate): all valid bits 0, stall_count 0. This forces fwd_a_sel = fwd_b_sel = 00 and stall = 0.
- Every rising edge (no reset): WB <= MEM and MEM <= EX, unconditionally. The back end never stalls.
- EX load rule:
  - If flush or stall, EX <= bubble (valid = 0).
  - Otherwise, EX <= ID fields with valid = id_valid.
- flush and stall together: bubble, the same as either alone.
- Load-use stall (combinational): stall = id_valid & !flush & EX.valid & EX.mem_read & EX.reg_write & EX.rd != 0 & ((id_use_rs1 & id_rs1 == EX.rd) | (id_use_rs2 & id_rs2 == EX.rd)).
  - flush suppresses stall, because the ID instruction is being killed.
- A stall lasts exactly one cycle per load. Next cycle the load is in MEM, so the condition deasserts and the consumer enters EX one cycle later.
- Forward select for operand A (operand B identical using rs2/use_rs2), combinational from flopped EX/MEM/WB state only. There is no path from the id_* inputs.
  - 01 if EX.use_rs1 & MEM.valid & MEM.reg_write & MEM.rd != 0 & MEM.rd == EX.rs1 & !MEM.mem_read.
  - else 10 if EX.use_rs1 & WB.valid & WB.reg_write & WB.rd != 0 & WB.rd == EX.rs1.
  - else 00.
  - If EX is a bubble (EX.valid = 0), both selects are 00.
- Priority: EX/MEM beats MEM/WB when both match, because the younger result wins.
- x0 is never forwarded.
- 2'b11 is never driven.
- A load in MEM matching EX is unreachable after the stall. Such a match yields 00, never 01.
- Load data forwarding happens only from WB (10).
- Register file is write-first, so an instruction in ID reading the WB destination needs no extra handling.
- stall_count: increments on each cycle where stall = 1 at the edge, saturating at 2^CNT_W-1.
- Reset mid-stall: state clears immediately and stall drops asynchronously.

Decomposition:
- Shared package (pipeline pkg):
  - Forward-select constants FWD_RF = 2'b00, FWD_EXMEM = 2'b01, FWD_MEMWB = 2'b10.
  - Stage-record struct {valid, rd, reg_write, mem_read}.
  - REG_AW.
- One natural sub-module: fwd_sel_unit, the combinational per-operand select. Instantiate it twice, for A and B.

Test Plan:
- Reset: assert rst mid-run with records populated -> fwd_a_sel = fwd_b_sel = 00, stall = 0, stall_count = 0 immediately.
- EX/MEM forward: add x5 then add x6,x5,x5 back-to-back -> with the consumer in EX, fwd_a_sel = fwd_b_sel = 01, stall = 0.
- Priority/double hazard:
  - Sequence: add x5; sub x5; or x7,x5,x0.
  - Required response: fwd_a_sel = 01 (not 10), fwd_b_sel = 00.
- Load-use:
  - Sequence: lw x8; add x9,x8,x1.
  - Required response: stall = 1 for exactly one cycle and EX valid = 0 the next cycle. Then fwd_a_sel = 10, fwd_b_sel = 00, and stall_count = 1.
- x0 and flush cases:
  - Writer to x0 followed by a reader of x0 -> selects 00.
  - lw x8 with flush = 1 during the dependent ID cycle -> stall = 0 and EX bubble.
- Saturation: force 2^CNT_W+3 stall cycles (CNT_W = 4 instance) -> stall_count holds 15.

Source files
------------

// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the EX-stage forwarding / hazard control.
//   REG_AW       : register-address width (x0..x31)
//   FWD_*        : operand mux select encodings
//   stage_rec_t  : per-stage destination record {valid, rd, reg_write, mem_read}
//   src_rec_t    : source-operand fields carried only by the EX record
//   writes_reg() : "this stage will write register r" (never true for x0)
package fwd_hazard_ctrl_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } stage_rec_t;

  typedef struct packed {
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              use_rs1;
    logic              use_rs2;
  } src_rec_t;

  function automatic logic writes_reg(input stage_rec_t s, input logic [REG_AW-1:0] r);
    return s.valid & s.reg_write & (s.rd != '0) & (s.rd == r);
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_fwd_sel_unit.sv
// Combinational forward select for one ALU operand.
//   ex_valid : EX holds a real instruction
//   use_rs   : EX instruction reads this operand
//   rs       : source register of this operand
//   mem, wb  : flopped MEM and WB stage records
//   sel      : FWD_RF / FWD_EXMEM / FWD_MEMWB (2'b11 never produced)
module fwd_sel_unit
  import fwd_hazard_ctrl_pkg::*;
(
  input  logic              ex_valid,
  input  logic              use_rs,
  input  logic [REG_AW-1:0] rs,
  input  stage_rec_t        mem,
  input  stage_rec_t        wb,
  output logic [1:0]        sel
);

  always_comb begin
    // NOTE: default assigned first so every path drives sel; no latch.
    sel = FWD_RF;
    if (ex_valid && use_rs) begin
      // Younger MEM result wins. A load in MEM has no data yet; it falls
      // through and its data is forwarded from WB on the following cycle.
      if (writes_reg(mem, rs) && !mem.mem_read) begin
        sel = FWD_EXMEM;
      end else if (writes_reg(wb, rs)) begin
        sel = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard control for the EX-stage operand muxes.
//   clk, rst          : pipeline clock, asynchronous active-high reset
//   id_*              : decode fields of the instruction currently in ID
//   flush             : taken branch/jump in EX; ID instruction is killed
//   fwd_a_sel/b_sel   : operand A/B mux selects (00 RF, 01 EX/MEM, 10 MEM/WB)
//   stall             : hold PC and IF/ID, bubble into ID/EX
//   stall_count       : saturating count of stall cycles
// REG_AW must match the package width used for the stage records.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::stage_rec_t;
  import fwd_hazard_ctrl_pkg::src_rec_t;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
);

  stage_rec_t ex_q, mem_q, wb_q;
  src_rec_t   ex_src_q;

  // Load in EX whose result the ID instruction needs: one bubble required.
  // A flushed ID instruction is discarded anyway, so it never stalls.
  assign stall = id_valid & ~flush
               & ex_q.valid & ex_q.mem_read & ex_q.reg_write & (ex_q.rd != '0)
               & ((id_use_rs1 & (id_rs1 == ex_q.rd)) |
                  (id_use_rs2 & (id_rs2 == ex_q.rd)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q     <= '0;
      ex_src_q <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
    end else begin
      // NOTE: non-blocking so the shift reads pre-edge values of every stage.
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (flush || stall) begin
        ex_q     <= '0;
        ex_src_q <= '0;
      end else begin
        ex_q     <= '{valid: id_valid, rd: id_rd,
                      reg_write: id_reg_write, mem_read: id_mem_read};
        ex_src_q <= '{rs1: id_rs1, rs2: id_rs2,
                      use_rs1: id_use_rs1, use_rs2: id_use_rs2};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

  fwd_sel_unit u_sel_a (
    .ex_valid (ex_q.valid),
    .use_rs   (ex_src_q.use_rs1),
    .rs       (ex_src_q.rs1),
    .mem      (mem_q),
    .wb       (wb_q),
    .sel      (fwd_a_sel)
  );

  fwd_sel_unit u_sel_b (
    .ex_valid (ex_q.valid),
    .use_rs   (ex_src_q.use_rs2),
    .rs       (ex_src_q.rs2),
    .mem      (mem_q),
    .wb       (wb_q),
    .sel      (fwd_b_sel)
  );

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed hazard scenarios, a
// randomized phase against an instruction-level pipeline model, reset
// mid-stall, and counter saturation on a CNT_W = 4 instance.
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read, flush;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [1:0] fwd_a_sel, fwd_b_sel, fwd_a_sel4, fwd_b_sel4;
  logic       stall, stall4;
  logic [15:0] stall_count;
  logic [3:0]  stall_count4;

  always #5 clk = ~clk;

  fwd_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall),
    .stall_count(stall_count)
  );

  fwd_hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .fwd_a_sel(fwd_a_sel4), .fwd_b_sel(fwd_b_sel4), .stall(stall4),
    .stall_count(stall_count4)
  );

  // Instruction-level model: pipe[0] = EX, pipe[1] = MEM, pipe[2] = WB.
  typedef struct {
    bit v;
    int rd, rs1, rs2;
    bit rw, ld, u1, u2;
  } ins_t;

  ins_t pipe[3];
  int   n_stall;
  int   total = 0;
  int   bad   = 0;

  function automatic bit produces(ins_t p, int r);
    return p.v && p.rw && (p.rd != 0) && (p.rd == r);
  endfunction

  // Newest completed result wins; a load still in MEM has no data to give.
  function automatic int model_sel(bit use_it, int rs);
    if (!pipe[0].v || !use_it) return 0;
    if (produces(pipe[1], rs) && !pipe[1].ld) return 1;
    if (produces(pipe[2], rs)) return 2;
    return 0;
  endfunction

  function automatic ins_t cur_id();
    ins_t t;
    t.v = id_valid; t.rd = int'(id_rd); t.rs1 = int'(id_rs1); t.rs2 = int'(id_rs2);
    t.rw = id_reg_write; t.ld = id_mem_read; t.u1 = id_use_rs1; t.u2 = id_use_rs2;
    return t;
  endfunction

  function automatic bit model_stall();
    ins_t id = cur_id();
    if (!id.v || flush || !pipe[0].ld) return 0;
    return (id.u1 && produces(pipe[0], id.rs1)) || (id.u2 && produces(pipe[0], id.rs2));
  endfunction

  function automatic int sat(int n, int maxv);
    return (n > maxv) ? maxv : n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
    n_stall = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input int rs1, input bit u1, input int rs2,
                       input bit u2, input int rd, input bit rw, input bit ld,
                       input bit fl);
    id_valid = v; id_rs1 = 5'(rs1); id_use_rs1 = u1; id_rs2 = 5'(rs2);
    id_use_rs2 = u2; id_rd = 5'(rd); id_reg_write = rw; id_mem_read = ld;
    flush = fl;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Called just after a negedge with ID inputs applied.
  task automatic settle(input string tag);
    #1;
    check({tag, "_a"},    32'(fwd_a_sel),    32'(model_sel(pipe[0].u1, pipe[0].rs1)));
    check({tag, "_b"},    32'(fwd_b_sel),    32'(model_sel(pipe[0].u2, pipe[0].rs2)));
    check({tag, "_st"},   32'(stall),        32'(model_stall()));
    check({tag, "_cnt"},  32'(stall_count),  32'(sat(n_stall, 65535)));
    check({tag, "_cnt4"}, 32'(stall_count4), 32'(sat(n_stall, 15)));
  endtask

  task automatic advance();
    bit   s  = model_stall();
    bit   f  = flush;
    ins_t id = cur_id();
    @(posedge clk);
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = (f || s) ? '{default: 0} : id;
    if (s) n_stall++;
    @(negedge clk);
  endtask

  task automatic drain();
    repeat (3) begin
      nop(); settle("drain"); advance();
    end
  endtask

  initial begin
    bit hold;
    rst = 1'b0;
    nop();
    model_reset();
    #1 rst = 1'b1;
    @(negedge clk); @(negedge clk);
    #1;
    check("rst_a",   32'(fwd_a_sel),   0);
    check("rst_b",   32'(fwd_b_sel),   0);
    check("rst_st",  32'(stall),       0);
    check("rst_cnt", 32'(stall_count), 0);
    rst = 1'b0;
    @(negedge clk);

    // add x5 ; add x6,x5,x5 -> both operands from EX/MEM
    drive(1, 1, 1, 2, 1, 5, 1, 0, 0); settle("exm0"); advance();
    drive(1, 5, 1, 5, 1, 6, 1, 0, 0); settle("exm1"); advance();
    nop(); settle("exm2");
    check("exmem_a",  32'(fwd_a_sel), 1);
    check("exmem_b",  32'(fwd_b_sel), 1);
    check("exmem_st", 32'(stall),     0);
    advance(); drain();

    // add x5 ; sub x5 ; or x7,x5,x0 -> younger sub wins, x0 never forwarded
    drive(1, 1, 1, 2, 1, 5, 1, 0, 0); settle("pri0"); advance();
    drive(1, 3, 1, 4, 1, 5, 1, 0, 0); settle("pri1"); advance();
    drive(1, 5, 1, 0, 1, 7, 1, 0, 0); settle("pri2"); advance();
    nop(); settle("pri3");
    check("prio_a", 32'(fwd_a_sel), 1);
    check("prio_b", 32'(fwd_b_sel), 0);
    advance(); drain();

    // lw x8 ; add x9,x8,x1 -> one stall, bubble, then MEM/WB forward
    drive(1, 2, 1, 0, 0, 8, 1, 1, 0); settle("lu0"); advance();
    drive(1, 8, 1, 1, 1, 9, 1, 0, 0); settle("lu1");
    check("lu_stall1", 32'(stall), 1);
    advance();
    settle("lu2");
    check("lu_stall2", 32'(stall),     0);
    check("lu_bub_a",  32'(fwd_a_sel), 0);
    advance();
    nop(); settle("lu3");
    check("lu_fwd_a", 32'(fwd_a_sel),   2);
    check("lu_fwd_b", 32'(fwd_b_sel),   0);
    check("lu_cnt",   32'(stall_count), 1);
    advance(); drain();

    // add x0 ; add x3,x0,x0 -> no forwarding of x0
    drive(1, 1, 1, 2, 1, 0, 1, 0, 0); settle("x0a"); advance();
    drive(1, 0, 1, 0, 1, 3, 1, 0, 0); settle("x0b"); advance();
    nop(); settle("x0c");
    check("x0_a", 32'(fwd_a_sel), 0);
    check("x0_b", 32'(fwd_b_sel), 0);
    advance(); drain();
    // lw x0 ; add using x0 -> no stall
    drive(1, 2, 1, 0, 0, 0, 1, 1, 0); settle("x0d"); advance();
    drive(1, 0, 1, 0, 1, 4, 1, 0, 0); settle("x0e");
    check("x0_nostall", 32'(stall), 0);
    advance(); drain();

    // lw x8 ; add x10,x8,x1 flushed ; add x11,x10,x10 -> no stall, no forward
    drive(1, 2, 1, 0, 0, 8, 1, 1, 0); settle("fl0"); advance();
    drive(1, 8, 1, 1, 1, 10, 1, 0, 1); settle("fl1");
    check("flush_nostall", 32'(stall), 0);
    advance();
    drive(1, 10, 1, 10, 1, 11, 1, 0, 0); settle("fl2"); advance();
    nop(); settle("fl3");
    check("flush_bub_a", 32'(fwd_a_sel), 0);
    check("flush_bub_b", 32'(fwd_b_sel), 0);
    advance(); drain();

    // Randomized traffic on a small register set; ID is held while stalled.
    hold = 0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
              $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
              $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 7) == 0);
      end else begin
        flush = ($urandom_range(0, 7) == 0);
      end
      settle("rnd");
      hold = model_stall();
      advance();
    end
    drain();

    // Reset while a stall is being asserted.
    drive(1, 2, 1, 0, 0, 8, 1, 1, 0); settle("mr0"); advance();
    drive(1, 8, 1, 1, 1, 9, 1, 0, 0); settle("mr1");
    check("mr_pre_stall", 32'(stall), 1);
    rst = 1'b1;
    #1;
    check("mr_a",   32'(fwd_a_sel),   0);
    check("mr_b",   32'(fwd_b_sel),   0);
    check("mr_st",  32'(stall),       0);
    check("mr_cnt", 32'(stall_count), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    nop();

    // 2^4 + 3 stalls: the 4-bit counter must hold at 15.
    repeat (19) begin
      drive(1, 2, 1, 0, 0, 8, 1, 1, 0); settle("sat0"); advance();
      drive(1, 8, 1, 1, 1, 9, 1, 0, 0); settle("sat1"); advance();
      settle("sat2"); advance();
    end
    nop(); settle("sat3");
    check("sat_cnt4", 32'(stall_count4), 15);
    check("sat_cnt",  32'(stall_count),  19);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
